// File: rtl/uart_pkg.sv
// Types shared by the UART receiver, transmitter and receive FIFO.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef struct packed {
        logic                       error;
        logic [UART_DATA_WIDTH-1:0] data;
    } uart_rx_entry_t;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } uart_parity_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the receive FIFO: synchronous write, asynchronous read, no reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_WIDTH + 1,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO with sticky overrun, saturating drop counter and character timeout.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_valid,
    input  logic                       in_error,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_error,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overrun,
    output logic [7:0]                 drop_cnt,
    input  logic                       overrun_clr,
    output logic                       rx_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  overrun_q, overrun_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;
    logic [TW-1:0]         idle_q, idle_d;
    logic                  empty, full_w, pop, wr_en, drop;
    logic [DATA_WIDTH:0]   head;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full_w = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop    = !empty && out_ready;
    // A same-cycle pop frees a slot, so a full FIFO can still accept the write.
    assign wr_en  = in_valid && (!full_w || pop);
    assign drop   = in_valid && full_w && !pop;

    uart_fifo_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata ({in_error, in_data}),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (head)
    );

    // Gate the unreset array so the outputs read zero while empty.
    assign out_data   = empty ? '0 : head[DATA_WIDTH-1:0];
    assign out_error  = !empty && head[DATA_WIDTH];
    assign out_valid  = !empty;
    assign count      = wr_ptr_q - rd_ptr_q;
    assign full       = full_w;
    assign overrun    = overrun_q;
    assign drop_cnt   = drop_cnt_q;
    assign rx_timeout = (idle_q == IDLE_MAX) && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;
        idle_d     = idle_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // A drop coinciding with a clear restarts the count at one.
        if (drop) begin
            overrun_d  = 1'b1;
            drop_cnt_d = overrun_clr ? 8'd1 : ((drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1);
        end else if (overrun_clr) begin
            overrun_d  = 1'b0;
            drop_cnt_d = 8'd0;
        end

        if (wr_en || pop || empty) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= 8'd0;
            idle_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
            idle_q     <= idle_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo with DEPTH = 4 and TIMEOUT_CYCLES = 8.
module tb_uart_rx_fifo;

    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_error;
    logic [DW-1:0] out_data;
    logic          out_error;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    count;
    logic          full;
    logic          overrun;
    logic [7:0]    drop_cnt;
    logic          overrun_clr;
    logic          rx_timeout;

    int testsRun = 0;
    int testsFailed = 0;
    logic [DW:0] scoreboard [$];

    uart_rx_fifo #(
        .DATA_WIDTH     (DW),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_error    (in_error),
        .out_data    (out_data),
        .out_error   (out_error),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .full        (full),
        .overrun     (overrun),
        .drop_cnt    (drop_cnt),
        .overrun_clr (overrun_clr),
        .rx_timeout  (rx_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one clock of inputs; the scoreboard checks the head on a pop and records accepted writes.
    task automatic applyStimulus(input logic vld, input logic [DW-1:0] data, input logic err,
                                 input logic rdy, input logic clr);
        logic modelPop;
        logic [DW:0] exp;
        in_valid    = vld;
        in_data     = data;
        in_error    = err;
        out_ready   = rdy;
        overrun_clr = clr;
        modelPop    = rdy && (scoreboard.size() != 0);
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, scoreboard.size() != 0});
        if (modelPop) begin
            exp = scoreboard.pop_front();
            checkOutput("head", {23'd0, out_error, out_data}, {23'd0, exp});
        end
        if (vld && (scoreboard.size() < DEPTH || modelPop)) begin
            scoreboard.push_back({err, data});
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        checkOutput("count", {29'd0, count}, scoreboard.size());
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic writeByte(input logic [DW-1:0] data, input logic err);
        applyStimulus(1'b1, data, err, 1'b0, 1'b0);
    endtask

    task automatic popByte();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_error = 1'b0;
        out_ready = 1'b0;
        overrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_count", {29'd0, count}, 32'd0);
        checkOutput("rst_full", {31'd0, full}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("rst_drop", {24'd0, drop_cnt}, 32'd0);
        checkOutput("rst_timeout", {31'd0, rx_timeout}, 32'd0);
        checkOutput("rst_data", {23'd0, out_error, out_data}, 32'd0);

        // Ordered read-back with an error flag in the middle
        writeByte(8'h55, 1'b0);
        writeByte(8'hA3, 1'b1);
        writeByte(8'h0F, 1'b0);
        checkOutput("t1_count3", {29'd0, count}, 32'd3);
        repeat (3) popByte();
        checkOutput("t1_empty", {31'd0, out_valid}, 32'd0);
        popByte();

        // Overflow: two dropped writes
        for (int i = 0; i < 6; i++) writeByte(8'h10 + 8'(i), 1'b0);
        checkOutput("t2_full", {31'd0, full}, 32'd1);
        checkOutput("t2_count", {29'd0, count}, 32'd4);
        checkOutput("t2_overrun", {31'd0, overrun}, 32'd1);
        checkOutput("t2_drop", {24'd0, drop_cnt}, 32'd2);
        repeat (4) popByte();
        checkOutput("t2_drained", {31'd0, out_valid}, 32'd0);

        // Full with a same-cycle pop: write is accepted
        for (int i = 0; i < 4; i++) writeByte(8'h20 + 8'(i), 1'b0);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        checkOutput("t3_count", {29'd0, count}, 32'd4);
        checkOutput("t3_drop", {24'd0, drop_cnt}, 32'd2);
        repeat (4) popByte();
        checkOutput("t3_drained", {31'd0, out_valid}, 32'd0);

        // Character timeout
        writeByte(8'h7E, 1'b0);
        for (int k = 1; k <= TMO + 2; k++) begin
            idleCycle();
            checkOutput($sformatf("t4_tmo_%0d", k), {31'd0, rx_timeout}, {31'd0, k >= TMO});
        end
        popByte();
        checkOutput("t4_tmo_clr", {31'd0, rx_timeout}, 32'd0);

        // Drop coinciding with overrun_clr
        for (int i = 0; i < 4; i++) writeByte(8'h30 + 8'(i), 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_overrun", {31'd0, overrun}, 32'd1);
        checkOutput("t5_drop", {24'd0, drop_cnt}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_clr_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("t5_clr_drop", {24'd0, drop_cnt}, 32'd0);

        // Reset mid-operation with count 3 and overrun set
        writeByte(8'hEF, 1'b0);
        popByte();
        checkOutput("t6_count3", {29'd0, count}, 32'd3);
        checkOutput("t6_overrun", {31'd0, overrun}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        scoreboard.delete();
        checkOutput("t6_count", {29'd0, count}, 32'd0);
        checkOutput("t6_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t6_ovr", {31'd0, overrun}, 32'd0);
        checkOutput("t6_drop", {24'd0, drop_cnt}, 32'd0);
        checkOutput("t6_tmo", {31'd0, rx_timeout}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each received character, along with its per-character error flag, into a synchronous FIFO. The FIFO presents characters to the host/bus side through a first-word-fall-through valid/ready interface. The block also flags overrun, because the receiver cannot be back-pressured, and raises a character-timeout indication for partially filled buffers.

## Interface
Parameters:
- DATA_WIDTH, 8: character width; matches the receiver's data width.
- DEPTH, 16: number of entries; must be a power of two, ≥ 2.
- TIMEOUT_CYCLES, 4096: idle clocks with a non-empty FIFO before `rx_timeout` asserts; must be ≥ 1.

Ports:
- clk  in  1  single clock domain for the whole block.
- rst  in  1  reset; synchronous and active-high (one clock, fixed polarity/synchronicity).
- in_data  in  DATA_WIDTH  character from the receiver.
- in_valid  in  1  one-cycle write strobe; there is no ready, so the input cannot be stalled.
- in_error  in  1  parity/framing error qualifying `in_data`.
- out_data  out  DATA_WIDTH  head-of-FIFO character.
- out_error  out  1  error flag stored with the head character.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head; a pop occurs when out_valid && out_ready.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- overrun  out  1  sticky; set when a write is dropped.
- drop_cnt  out  8  saturating count of dropped characters.
- overrun_clr  in  1  clears `overrun` and `drop_cnt`.
- rx_timeout  out  1  character timeout: the FIFO is non-empty and has been idle.

## Operation
- Storage: DEPTH entries of {error, data}, i.e. DATA_WIDTH+1 bits. Read and write pointers are $clog2(DEPTH)+1 bits wide, including a wrap bit.
  - empty is ptrs equal.
  - full is the index bits equal with the wrap bits different.
  - Pointers wrap naturally modulo 2·DEPTH.
- Write: when `in_valid` is high and either the FIFO is not full or a pop happens in the same cycle, store the entry at wr_ptr and increment wr_ptr.
- Drop: when `in_valid` is high, the FIFO is full and there is no same-cycle pop:
  - the character is discarded;
  - `overrun` is set;
  - `drop_cnt` increments, saturating at 255.
- Pop: on out_valid && out_ready, increment rd_ptr. When the FIFO is empty, out_ready is ignored.
- Simultaneous write and pop:
  - Both take effect and `count` is unchanged.
  - On empty, only the write occurs; there is no bypass.
- FWFT output:
  - `out_data` and `out_error` are always the entry at rd_ptr.
  - `out_valid` = !empty.
  - Contents are undefined when out_valid = 0.
- overrun_clr:
  - Clears `overrun` and `drop_cnt` on the next edge.
  - If a drop occurs in the same cycle, the drop wins: overrun = 1 and drop_cnt = 1.
- Timeout counter:
  - Cleared on any write, any pop, or whenever the FIFO is empty.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - `rx_timeout` = (counter == TIMEOUT_CYCLES) && !empty.
- Dropped writes do not count as activity for the timeout.

## Timing
- Reset values:
  - out_valid 0, count 0, full 0, overrun 0, drop_cnt 0, rx_timeout 0.
  - out_data and out_error 0; the storage array itself is not reset.
- Reset mid-operation: all contents are discarded and the pointers are zeroed; this takes effect on the next edge.
- Latency: a character written at edge N gives out_valid = 1 and data visible after edge N, i.e. usable in cycle N+1.
- A pop at edge N gives the next entry (or out_valid = 0) in cycle N+1.
- `count`, `full`, `overrun` and `drop_cnt` are registered and update at the same edge as the event that changes them.
- `rx_timeout` asserts TIMEOUT_CYCLES clocks after the last activity. It drops at the edge of the next write, the next pop, or the FIFO becoming empty.

## Structure
- Shared package `uart_pkg`:
  - the `uart_rx_entry_t` packed struct {logic error; logic [DATA_WIDTH-1:0] data};
  - the parity mode enum (NONE = 0, EVEN = 1, ODD = 2), shared with the receiver and transmitter.
- One sub-module, `uart_fifo_mem`: a plain synchronous-write, asynchronous-read array. Pointer, flag, overrun and timeout logic stay in `uart_rx_fifo`.

## Test plan
Benches use DEPTH = 4 and TIMEOUT_CYCLES = 8 unless stated otherwise.
- Write 0x55, 0xA3 (error = 1), 0x0F with out_ready = 0, then raise out_ready → reads 0x55/0, 0xA3/1, 0x0F/0 in order; count goes 3 → 0; out_valid then drops.
- Fill with 4 writes, then 2 more writes with no pop → full = 1, count = 4, overrun = 1, drop_cnt = 2; reading returns the first 4 characters only.
- FIFO full with in_valid and a pop in the same cycle → write accepted; count stays 4; the new byte appears as the last entry read.
- Write 0x7E with no further activity → rx_timeout = 1 exactly 8 clocks after the write; a pop clears it at the next edge.
- Drop in the same cycle as overrun_clr → overrun = 1, drop_cnt = 1. A later overrun_clr alone → both return to 0.
- rst asserted with count = 3 and overrun = 1 → next cycle: count 0, out_valid 0, overrun 0, drop_cnt 0, rx_timeout 0.
